// File: rtl/sevseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: double-buffered frame intake,
// one shared hex decoder driven per digit, registered segment/anode outputs.
module sevseg_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  output logic                  ready,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [3:0]            hex_out,
  input  logic [6:0]            seg_in,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_done
);

  localparam int IDX_W   = $clog2(DIGITS);
  localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GUARD, ON} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               transfer, frame_end, accept;

  logic                shadow_full;
  logic [4*DIGITS-1:0] shadow_data, active_data;
  logic [DIGITS-1:0]   shadow_blank, active_blank;
  logic [DIGITS-1:0]   shadow_dp, active_dp;

  logic [3:0]          cur_nibble;
  logic                cur_blank, cur_dp;
  logic [DIGITS-1:0]   cur_an;
  logic                lit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    transfer   = 1'b0;
    frame_end  = 1'b0;
    case (state)
      IDLE: begin
        if (shadow_full) begin
          transfer   = 1'b1;
          idx_next   = '0;
          cnt_next   = '0;
          state_next = GUARD;
        end
      end
      GUARD: begin
        if (cnt == GUARD_LAST) begin
          cnt_next   = '0;
          state_next = ON;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ON: begin
        if (cnt == ON_LAST) begin
          cnt_next   = '0;
          state_next = GUARD;
          if (idx == LAST_IDX) begin
            // Frame wrap: rescan the active frame unless a new one is waiting.
            frame_end = 1'b1;
            idx_next  = '0;
            transfer  = shadow_full;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Accept and transfer are exclusive: one needs the shadow empty, the other full.
  assign accept = load && !shadow_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_full  <= 1'b0;
      shadow_data  <= '0;
      shadow_blank <= '0;
      shadow_dp    <= '0;
      active_data  <= '0;
      active_blank <= '0;
      active_dp    <= '0;
    end else begin
      if (transfer) begin
        active_data  <= shadow_data;
        active_blank <= shadow_blank;
        active_dp    <= shadow_dp;
        shadow_full  <= 1'b0;
      end
      if (accept) begin
        shadow_data  <= data_in;
        shadow_blank <= blank_in;
        shadow_dp    <= dp_in;
        shadow_full  <= 1'b1;
      end
    end
  end

  always_comb begin
    cur_nibble = '0;
    cur_blank  = 1'b0;
    cur_dp     = 1'b0;
    cur_an     = '1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nibble = active_data[4*k +: 4];
        cur_blank  = active_blank[k];
        cur_dp     = active_dp[k];
        cur_an[k]  = 1'b0;
      end
    end
  end

  assign lit        = (state == ON) && !cur_blank;
  assign hex_out    = (state == IDLE) ? 4'h0 : cur_nibble;
  assign ready      = !shadow_full;
  assign frame_done = frame_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out <= '0;
      dp_out  <= 1'b0;
      an_out  <= '1;
    end else begin
      seg_out <= seg_in;
      dp_out  <= lit && cur_dp;
      an_out  <= lit ? cur_an : '1;
    end
  end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Randomized bench for sevseg_scan_ctrl against a frame-timeline reference
// model (position within the frame period decides digit and phase).
module tb_sevseg_scan_ctrl;

  localparam int D      = 4;
  localparam int R      = 4;
  localparam int G      = 1;
  localparam int PH     = G + R;
  localparam int PERIOD = D * PH;

  logic          clk = 1'b0;
  logic          rst, load;
  logic          ready;
  logic [4*D-1:0] data_in;
  logic [D-1:0]  blank_in, dp_in;
  logic [3:0]    hex_out;
  logic [6:0]    seg_in, seg_out;
  logic          dp_out;
  logic [D-1:0]  an_out;
  logic          frame_done;

  sevseg_scan_ctrl #(
    .DIGITS       (D),
    .REFRESH_DIV  (R),
    .GUARD_CYCLES (G)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .ready      (ready),
    .data_in    (data_in),
    .blank_in   (blank_in),
    .dp_in      (dp_in),
    .hex_out    (hex_out),
    .seg_in     (seg_in),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  assign seg_in = hex7(hex_out);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: m_t = -1 while idle, else cycle position inside the frame.
  int             m_t;
  logic           m_full;
  logic [4*D-1:0] m_sd, m_ad;
  logic [D-1:0]   m_sb, m_sp, m_ab, m_ap;
  logic [D-1:0]   exp_an;
  logic [6:0]     exp_seg;
  logic           exp_dp;
  logic           m_valid = 1'b0;
  int             m_d;
  logic           m_on, m_acc;
  logic [3:0]     m_h;
  int             cyc = 0;
  int             last_fd = -1;

  always @(posedge clk) begin
    cyc++;
    m_valid = 1'b1;
    if (rst) begin
      m_t = -1; m_full = 1'b0;
      m_sd = '0; m_sb = '0; m_sp = '0; m_ad = '0; m_ab = '0; m_ap = '0;
      exp_an = '1; exp_seg = '0; exp_dp = 1'b0;
      last_fd = -1;
    end else begin
      if (m_t < 0) begin
        m_d = 0; m_on = 1'b0; m_h = 4'h0;
      end else begin
        m_d  = m_t / PH;
        m_on = (m_t % PH) >= G;
        m_h  = m_ad[4*m_d +: 4];
      end
      exp_seg = hex7(m_h);
      exp_an  = '1;
      if (m_on && !m_ab[m_d]) exp_an[m_d] = 1'b0;
      exp_dp  = m_on && !m_ab[m_d] && m_ap[m_d];
      m_acc   = load && !m_full;
      if (m_t < 0) begin
        if (m_full) begin
          m_ad = m_sd; m_ab = m_sb; m_ap = m_sp; m_full = 1'b0; m_t = 0;
        end
      end else begin
        if (m_t == PERIOD - 1 && m_full) begin
          m_ad = m_sd; m_ab = m_sb; m_ap = m_sp; m_full = 1'b0;
        end
        m_t = (m_t + 1) % PERIOD;
      end
      if (m_acc) begin
        m_sd = data_in; m_sb = blank_in; m_sp = dp_in; m_full = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("ready", ready, !m_full);
      check("frame_done", frame_done, (m_t == PERIOD - 1));
      check("hex_out", hex_out, (m_t < 0) ? 4'h0 : m_ad[4*(m_t/PH) +: 4]);
      check("an_out", an_out, exp_an);
      check("seg_out", seg_out, exp_seg);
      check("dp_out", dp_out, exp_dp);
      check("an_onehot", ($countones(~an_out) <= 1), 1);
      if (frame_done) begin
        if (last_fd >= 0) check("fd_period", cyc - last_fd, PERIOD);
        last_fd = cyc;
      end
    end
  end

  task automatic drive(input logic l, input logic [4*D-1:0] d,
                       input logic [D-1:0] b, input logic [D-1:0] p);
    @(negedge clk); #1;
    load = l; data_in = d; blank_in = b; dp_in = p;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0);
  endtask

  task automatic wait_fd(input string tag);
    bit seen = 0;
    for (int i = 0; i < 4 * PERIOD; i++) begin
      @(negedge clk);
      if (frame_done) begin seen = 1; break; end
    end
    if (!seen) check(tag, 0, 1);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data_in = '0; blank_in = '0; dp_in = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_an", an_out, 4'b1111);
    check("rst_seg", seg_out, 7'd0);
    check("rst_fd", frame_done, 1'b0);
    #1 rst = 1'b0;
    idle_cycles(50);

    // First frame, then a mid-frame load and an ignored second load.
    drive(1'b1, 16'h3210, 4'b0000, 4'b0000);
    drive(1'b0, '0, '0, '0);
    check("ready_drop", ready, 1'b0);
    idle_cycles(30);
    drive(1'b1, 16'hFEDC, 4'b0000, 4'b0000);
    drive(1'b1, 16'h9999, 4'b0000, 4'b0000);
    idle_cycles(50);

    // Blanking and decimal point.
    drive(1'b1, 16'h5678, 4'b0100, 4'b0001);
    idle_cycles(60);

    // Load coincident with the frame-end transfer is refused, next cycle taken.
    wait_fd("wait_fd0");
    drive(1'b1, 16'hABCD, 4'b0000, 4'b0010);
    drive(1'b0, '0, '0, '0);
    wait_fd("wait_fd1");
    check("fe_full", ready, 1'b0);
    #1 load = 1'b1; data_in = 16'h1357; blank_in = 4'b1000; dp_in = 4'b0100;
    @(negedge clk);
    check("fe_free", ready, 1'b1);
    drive(1'b0, '0, '0, '0);
    check("fe_taken", ready, 1'b0);
    idle_cycles(60);

    // Reset during digit 2's ON phase.
    begin
      bit seen = 0;
      for (int i = 0; i < 4 * PERIOD; i++) begin
        @(negedge clk);
        if (an_out == 4'b1011) begin seen = 1; break; end
      end
      if (!seen) check("wait_dig2", 0, 1);
    end
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_an", an_out, 4'b1111);
    check("mid_rst_ready", ready, 1'b1);
    check("mid_rst_hex", hex_out, 4'h0);
    #1 rst = 1'b0;
    idle_cycles(40);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      load     = ($urandom_range(0, 7) == 0);
      data_in  = 16'($urandom);
      blank_in = 4'($urandom);
      dp_in    = 4'($urandom);
      rst      = ($urandom_range(0, 499) == 0);
    end
    #1 rst = 1'b0; load = 1'b0;
    idle_cycles(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sevseg_scan_ctrl.md
# sevseg_scan_ctrl

Time-multiplexing scan controller that shares one combinational hex-to-seven-segment decoder across a DIGITS-wide common-anode display. It accepts a frame of hex nibbles, blank flags and decimal points over a valid/ready handshake into a shadow buffer. It drives the shared decoder's 4-bit input one digit at a time and registers the decoder's a–g outputs together with the matching anode select. A guard interval between digits suppresses ghosting.

## Interface
- DIGITS, 4: number of display digits; legal range 2..8.
- REFRESH_DIV, 1000: ON-phase length per digit, in clk cycles; minimum 2.
- GUARD_CYCLES, 2: all-anodes-off interval before each digit's ON phase; minimum 1.
- clk  input  1  single system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  frame valid.
- ready  output  1  shadow buffer empty; a frame is accepted when load && ready.
- data_in  input  4*DIGITS  hex nibbles; digit k is data_in[4k+3:4k], and digit 0 is scanned first.
- blank_in  input  DIGITS  1 = digit k is dark for the whole frame.
- dp_in  input  DIGITS  decimal point per digit, active-high.
- hex_out  output  4  nibble to the shared decoder's {i3,i2,i1,i0}.
- seg_in  input  7  decoder outputs {a,b,c,d,e,f,g}, active-high, combinational from hex_out.
- seg_out  output  7  registered segments {a..g}, active-high.
- dp_out  output  1  registered decimal point, active-high.
- an_out  output  DIGITS  registered anode enables, active-low.
- frame_done  output  1  one-cycle pulse at the end of each scanned frame.

## Operation
- Buffers:
  - The shadow register holds {data, blank, dp} plus a full flag.
  - The active register holds the frame being scanned.
  - ready = !shadow_full.
- Accept: on a cycle with load && ready, the block captures data_in, blank_in and dp_in into the shadow register and sets shadow_full. A load while ready=0 is ignored; nothing is captured.
- State machine: IDLE, GUARD, ON. The digit index idx runs from 0 to DIGITS-1. A phase counter cnt counts the cycles spent in the current phase.
- IDLE:
  - Entered from reset.
  - If shadow_full: shadow is copied to active, shadow_full is cleared, idx=0, and the next state is GUARD.
- GUARD:
  - The block stays GUARD_CYCLES cycles, then goes to ON.
  - The registered anode value is all ones.
- ON:
  - The block stays REFRESH_DIV cycles.
  - On the last ON cycle with idx<DIGITS-1: idx+1, next state GUARD.
  - On the last ON cycle with idx=DIGITS-1 (the frame end): frame_done=1 and idx wraps to 0.
    - If shadow_full: shadow is copied to active, shadow_full is cleared, next state GUARD.
    - Otherwise: the active frame is kept and rescanned, next state GUARD.
  - The block never returns to IDLE except via rst.
- hex_out = active nibble[idx], combinational from registered state, and is held for the whole GUARD+ON of digit idx.
  - In IDLE, hex_out=0.
- Output register, updated every cycle:
  - seg_out <= seg_in.
  - dp_out <= ON && !blank[idx] && dp[idx].
  - an_out <= ~(onehot(idx)) when state=ON and !blank[idx]; otherwise all ones.
  - During a blanked digit's ON phase, seg_out still follows seg_in, but an_out stays all ones and dp_out=0.
- Simultaneous events:
  - At frame end, a shadow transfer occurs while ready=0 that same cycle, so a coincident load is not accepted. ready is 1 on the following cycle.
  - A load can be accepted during any cycle of the frame, including GUARD phases, when ready=1.
- Reset mid-operation: on the next edge, all state returns to reset values, and both buffers and any pending frame are discarded.

## Timing
- Reset values:
  - state=IDLE, idx=0, cnt=0, shadow_full=0, active register=0.
  - ready=1, hex_out=0, seg_out=0, dp_out=0, an_out=all ones, frame_done=0.
- Frame start from IDLE:
  - Load is accepted at edge E.
  - At E+1, IDLE sees shadow_full and performs the transfer.
  - GUARD for digit 0 begins at E+2.
- Let t0 be the first GUARD cycle of digit k.
  - GUARD occupies cycles t0..t0+G-1.
  - ON occupies cycles t0+G..t0+G+R-1.
  - an_out[k]=0 and the digit's seg_out/dp_out are valid in cycles t0+G+1..t0+G+R, one cycle of register latency.
- Frame period = DIGITS*(GUARD_CYCLES+REFRESH_DIV) cycles, exactly, with no extra cycles at the wrap.
- frame_done is high only on the last ON cycle of digit DIGITS-1.
- Rescanning or transferring a new frame at the wrap does not change the period.
- At most one bit of an_out is low in any cycle. Between two lit digits there are always at least GUARD_CYCLES consecutive cycles of all-ones an_out.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1.
- Reset:
  - Hold rst for 3 cycles.
  - Expect ready=1, an_out=4'b1111, seg_out=0, frame_done=0.
  - Expect no anode activity for 50 cycles with load=0.
- First frame, load data_in=16'h3210 and blank=0:
  - GUARD for digit 0 starts 2 cycles after the accept.
  - an_out sequence is 1110, 1101, 1011, 0111, each low for 4 cycles, separated by 1 cycle of 1111.
  - seg_out for digit 0 = 7'b1111110 and for digit 1 = 7'b0110000.
  - frame_done pulses every 20 cycles.
- Double buffering:
  - Load 16'hFEDC mid-frame; expect ready to drop to 0 the cycle after the accept.
  - A second load while ready=0 is ignored.
  - The new frame first appears on digit 0 after frame_done, and ready returns to 1 on the cycle after the transfer.
- Blanking and decimal point, with blank_in=4'b0100 and dp_in=4'b0001:
  - Digit 2's ON phase shows an_out=1111.
  - dp_out=1 only during digit 0's lit cycles.
  - The frame period remains 20 cycles.
- Load at frame end:
  - Assert load on the frame_done cycle while the shadow is full; expect no accept.
  - Hold load one more cycle; expect it to be accepted.
- Reset mid-frame:
  - Assert rst during digit 2's ON phase.
  - At the next edge, expect an_out=1111, ready=1 and state IDLE.
  - The old frame is never redisplayed.
